// File: rtl/weight_loader.sv
// Weight-buffer loader: takes a load command, streams DDR beats into the bank groups,
// and advances one buffer address after every GROUPS beats.
module weight_loader #(
    parameter int ADDR_LEN     = 16,
    parameter int DATA_LEN     = 64,
    parameter int DDR_DATA_LEN = 256,
    parameter int BUFFER_NUM   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_LEN-1:0]     cmd_addr,
    input  logic [ADDR_LEN-1:0]     cmd_len,
    input  logic [DDR_DATA_LEN-1:0] ddr_data,
    input  logic                    ddr_valid,
    output logic                    ddr_ready,
    output logic [DDR_DATA_LEN-1:0] data_wr,
    output logic [ADDR_LEN-1:0]     wr_addr,
    output logic [BUFFER_NUM-1:0]   wr_en,
    output logic                    busy,
    output logic                    done
);
    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // LOAD  | accepting DDR beats, ddr_ready high
    // DONE  | one-cycle completion, done high
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int LANES  = DDR_DATA_LEN / DATA_LEN;
    localparam int GROUPS = BUFFER_NUM * DATA_LEN / DDR_DATA_LEN;
    localparam int G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [G_W-1:0] G_LAST = G_W'(GROUPS - 1);

    logic [1:0]          state;
    logic [ADDR_LEN-1:0] addr_cnt;
    logic [ADDR_LEN-1:0] rem_cnt;
    logic [G_W-1:0]      g_cnt;

    assign cmd_ready = (state == IDLE);
    assign ddr_ready = (state == LOAD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_cnt <= '0;
            rem_cnt  <= '0;
            g_cnt    <= '0;
            data_wr  <= '0;
            wr_addr  <= '0;
            wr_en    <= '0;
        end else begin
            wr_en <= '0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_cnt <= cmd_addr;
                        rem_cnt  <= cmd_len;
                        g_cnt    <= '0;
                        state    <= (cmd_len == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (ddr_valid) begin
                        data_wr <= ddr_data;
                        wr_addr <= addr_cnt;
                        wr_en[g_cnt*LANES +: LANES] <= '1;
                        // last group of this address: step to the next address
                        if (g_cnt == G_LAST) begin
                            g_cnt    <= '0;
                            addr_cnt <= addr_cnt + ADDR_LEN'(1);
                            rem_cnt  <= rem_cnt - ADDR_LEN'(1);
                            if (rem_cnt == ADDR_LEN'(1))
                                state <= DONE;
                        end else begin
                            g_cnt <= g_cnt + G_W'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: each accepted beat pushes its expected write to a
// scoreboard, which is popped and compared against the registered write one cycle later.
module tb_weight_loader;
    localparam int AL = 16;
    localparam int DW = 256;
    localparam int BN = 32;
    localparam int GR = 8;

    typedef struct packed {
        logic [AL-1:0] addr;
        logic [BN-1:0] en;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AL-1:0] cmd_addr;
    logic [AL-1:0] cmd_len;
    logic [DW-1:0] ddr_data;
    logic          ddr_valid;
    logic          ddr_ready;
    logic [DW-1:0] data_wr;
    logic [AL-1:0] wr_addr;
    logic [BN-1:0] wr_en;
    logic          busy;
    logic          done;

    weight_loader dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ddr_data(ddr_data), .ddr_valid(ddr_valid), .ddr_ready(ddr_ready),
        .data_wr(data_wr), .wr_addr(wr_addr), .wr_en(wr_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    int            ms = 0;            // expected state: 0 idle, 1 load, 2 done
    logic [AL-1:0] base;
    int            total;
    int            k;
    logic [AL-1:0] last_addr;
    logic [DW-1:0] last_data;
    int            wr_obs;
    int            done_obs;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock: check state-derived outputs, predict the edge, then check registered outputs.
    task automatic step();
        exp_t e;
        logic pend;
        int   nms;
        pend = 1'b0;
        nms  = ms;
        chk("cmd_ready", cmd_ready, ms == 0);
        chk("ddr_ready", ddr_ready, ms == 1);
        chk("busy", busy, ms != 0);
        chk("done", done, ms == 2);
        if (done === 1'b1) done_obs++;
        if (!rst_n) begin
            nms = 0;
        end else begin
            case (ms)
                0: if (cmd_valid) begin
                    base  = cmd_addr;
                    total = GR * int'(cmd_len);
                    k     = 0;
                    nms   = (cmd_len == '0) ? 2 : 1;
                end
                1: if (ddr_valid) begin
                    e.addr = base + AL'(k / GR);
                    e.en   = 32'h0000_000F << (4 * (k % GR));
                    e.data = ddr_data;
                    e.last = (k == total - 1);
                    sb.push_back(e);
                    k++;
                    pend = 1'b1;
                    if (e.last) nms = 2;
                end
                default: nms = 0;
            endcase
        end
        @(posedge clk);
        #1;
        ms = nms;
        if (pend) begin
            e = sb.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_en", wr_en, e.en);
            chk("data_wr", data_wr, e.data);
            last_addr = e.addr;
            last_data = e.data;
        end else if (!rst_n) begin
            chk("rst_wr_en", wr_en, '0);
            chk("rst_wr_addr", wr_addr, '0);
            chk("rst_data_wr", data_wr, '0);
            last_addr = '0;
            last_data = '0;
        end else begin
            chk("idle_wr_en", wr_en, '0);
            chk("hold_wr_addr", wr_addr, last_addr);
            chk("hold_data_wr", data_wr, last_data);
        end
        if (wr_en !== '0) wr_obs++;
    endtask

    task automatic issue(input logic [AL-1:0] a, input logic [AL-1:0] l);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    // mode 0: back-to-back beats, mode 1: ddr_valid every other cycle
    task automatic run_beats(input int mode, input int limit);
        int n = 0;
        while (ms != 0 && n < limit) begin
            ddr_valid = (mode == 0) || (n % 2 == 0);
            ddr_data  = rnd256();
            step();
            n++;
        end
        ddr_valid = 1'b0;
        chk("load_bound", n < limit, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        ddr_valid = 1'b0; ddr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wr_en", wr_en, '0);
        chk("reset_data_wr", data_wr, '0);
        chk("reset_wr_addr", wr_addr, '0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        last_addr = '0;
        last_data = '0;
        ms = 0;
        rst_n = 1'b1;
        step();

        // two addresses back-to-back, with a stray command offered mid-load
        wr_obs = 0; done_obs = 0;
        issue(16'h0010, 16'd2);
        for (int i = 0; i < 16; i++) begin
            ddr_valid = 1'b1;
            ddr_data  = rnd256();
            cmd_valid = (i >= 3 && i < 6);
            cmd_addr  = 16'h1234;
            cmd_len   = 16'd5;
            step();
        end
        cmd_valid = 1'b0; ddr_valid = 1'b0;
        step();
        step();
        chk("t1_wr_pulses", wr_obs, 16);
        chk("t1_done_pulses", done_obs, 1);

        // gapped beats
        wr_obs = 0; done_obs = 0;
        issue(16'h0020, 16'd1);
        run_beats(1, 100);
        step();
        chk("t2_wr_pulses", wr_obs, 8);
        chk("t2_done_pulses", done_obs, 1);

        // address wrap
        issue(16'hFFFF, 16'd2);
        run_beats(0, 100);
        step();

        // zero-length command with ddr_valid held high
        wr_obs = 0; done_obs = 0;
        ddr_valid = 1'b1;
        ddr_data  = rnd256();
        issue(16'h0100, 16'd0);
        step();
        step();
        ddr_valid = 1'b0;
        chk("t4_wr_pulses", wr_obs, 0);
        chk("t4_done_pulses", done_obs, 1);

        // reset in the middle of a load, then a fresh command
        issue(16'h0040, 16'd1);
        for (int i = 0; i < 4; i++) begin
            ddr_valid = 1'b1;
            ddr_data  = rnd256();
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wr_obs = 0;
        for (int i = 0; i < 3; i++) begin
            ddr_data = rnd256();
            step();
        end
        ddr_valid = 1'b0;
        chk("t5_no_wr_after_reset", wr_obs, 0);
        issue(16'h0005, 16'd1);
        run_beats(0, 100);
        step();

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL provide parameter ADDR_LEN, default 16, weight-buffer address width.
REQ-002 SHALL provide parameter DATA_LEN, default 64, width of one buffer bank.
REQ-003 SHALL provide parameter DDR_DATA_LEN, default 256, DDR beat width.
REQ-004 SHALL provide parameter BUFFER_NUM, default 32, bank count; GROUPS = BUFFER_NUM*DATA_LEN/DDR_DATA_LEN (default 8), integer power of two.
REQ-005 SHALL have ports:
  clk  in  1  clock
  rst_n  in  1  reset, synchronous, active-low
  cmd_valid  in  1  load command offered
  cmd_ready  out  1  command accepted when high with cmd_valid
  cmd_addr  in  ADDR_LEN  first buffer address
  cmd_len  in  ADDR_LEN  number of buffer addresses to fill
  ddr_data  in  DDR_DATA_LEN  DDR beat
  ddr_valid  in  1  beat offered
  ddr_ready  out  1  beat accepted when high with ddr_valid
  data_wr  out  DDR_DATA_LEN  write data to weight buffer
  wr_addr  out  ADDR_LEN  write address to weight buffer
  wr_en  out  BUFFER_NUM  per-bank write enable
  busy  out  1  load in progress
  done  out  1  one-cycle completion pulse

Function
REQ-006 SHALL implement states IDLE, LOAD, DONE; reset state IDLE.
REQ-007 SHALL drive cmd_ready = (state==IDLE), combinational from state.
REQ-008 SHALL, on cmd_valid&&cmd_ready, latch cmd_addr into address counter, cmd_len into remaining counter, clear group counter g; go LOAD if cmd_len!=0, else DONE.
REQ-009 SHALL drive ddr_ready = (state==LOAD), combinational from state; ddr_valid outside LOAD has no effect.
REQ-010 SHALL, for beat accepted in cycle t, register in cycle t+1: data_wr = ddr_data, wr_addr = address counter, wr_en bits [g*DDR_DATA_LEN/DATA_LEN +: DDR_DATA_LEN/DATA_LEN] = 1, all other bits 0.
REQ-011 SHALL drive wr_en all-zero in every cycle not following an accepted beat; data_wr/wr_addr hold last value.
REQ-012 SHALL increment g per accepted beat; at g==GROUPS-1 wrap g to 0, increment address counter (modulo 2^ADDR_LEN), decrement remaining.
REQ-013 SHALL, on accepting beat with g==GROUPS-1 and remaining==1, enter DONE in t+1.
REQ-014 SHALL assert done exactly one cycle, the cycle state==DONE (coincident with last wr_en), then return to IDLE.
REQ-015 SHALL drive busy = (state!=IDLE).
REQ-016 SHALL tolerate ddr_valid gaps of any length; counters advance only on accepted beats.
REQ-017 SHALL wrap address 2^ADDR_LEN-1 to 0 without error.
REQ-018 SHALL ignore cmd_valid while busy; no queueing.

Reset
REQ-019 SHALL, on rst_n low at clk edge, set state IDLE, counters 0, wr_en 0, data_wr 0, wr_addr 0, done 0, busy 0, regardless of state.
REQ-020 SHALL discard partial load on mid-operation reset; no wr_en pulses in or after the reset cycle until new command.

Verification
REQ-021 SHALL cover: cmd_addr=0x0010, cmd_len=2, 16 back-to-back beats -> wr_addr 0x0010 for beats 0-7 then 0x0011, wr_en 0x0000000F,0x000000F0,...,0xF0000000 repeating, done in cycle after beat 15, busy low next cycle.
REQ-022 SHALL cover: cmd_len=1 with ddr_valid toggling every other cycle -> exactly 8 wr_en pulses, each one cycle after acceptance, done once.
REQ-023 SHALL cover: cmd_addr=0xFFFF, cmd_len=2 -> second address 0x0000.
REQ-024 SHALL cover: cmd_len=0 -> no wr_en, ddr_ready never high, done pulse one cycle after accept, cmd_ready high following cycle.
REQ-025 SHALL cover: rst_n low after beat 3 of cmd_len=1 -> all outputs 0 next cycle, IDLE, subsequent command cmd_addr=0x0005, cmd_len=1 writes from group 0 at 0x0005.
REQ-026 SHALL cover: cmd_valid asserted during LOAD -> ignored, cmd_ready low, active load unaffected.
